// File: rtl/instruction_fetch.sv
// Front-end fetch stage: program RAM, PC, and LOAD/RUN/HALT control feeding decode.
// Redirects (branch over jump) outrank stall, and stall outranks halt detection and fetch.
module instruction_fetch #(
  parameter int          INSTR_W = 19,
  parameter int          PC_W    = 4,
  parameter logic [2:0]  HALT_OP = 3'b111
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               start,
  input  logic               stall,
  input  logic               jump_req,
  input  logic [PC_W-1:0]    jump_target,
  input  logic               branch_req,
  input  logic [PC_W-1:0]    branch_target,
  output logic [INSTR_W-1:0] instruction_code,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc_out,
  output logic               flush_jump,
  output logic               branch_flush,
  output logic               running,
  output logic               halted
);

  localparam int DEPTH = 1 << PC_W;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [PC_W-1:0]      pc_out_q, pc_out_d;
  logic [INSTR_W-1:0]   ic_q, ic_d;
  logic                 vld_q, vld_d;
  logic                 running_q, running_d;
  logic                 halted_q, halted_d;
  logic [INSTR_W-1:0]   mem_q [DEPTH];

  logic                 in_run;
  logic [INSTR_W-1:0]   fetch_word;

  assign in_run     = (state_q == S_RUN);
  assign fetch_word = mem_q[pc_q];

  assign branch_flush = in_run & branch_req;
  assign flush_jump   = in_run & jump_req & ~branch_req;

  // RAM has no reset so a program survives a reset_n pulse.
  always_ff @(posedge clk) begin
    if (reset_n && (state_q == S_LOAD) && prog_we)
      mem_q[prog_addr] <= prog_data;
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    ic_d     = ic_q;
    vld_d    = vld_q;
    unique case (state_q)
      S_LOAD: begin
        ic_d  = '0;
        vld_d = 1'b0;
        if (start) begin
          state_d = S_RUN;
          pc_d    = '0;
        end
      end
      S_RUN: begin
        if (branch_req) begin
          pc_d  = branch_target;
          ic_d  = '0;
          vld_d = 1'b0;
        end else if (jump_req) begin
          pc_d  = jump_target;
          ic_d  = '0;
          vld_d = 1'b0;
        end else if (stall) begin
          // everything already holds
        end else if (fetch_word[2:0] == HALT_OP) begin
          state_d = S_HALT;
          ic_d    = '0;
          vld_d   = 1'b0;
        end else begin
          ic_d     = fetch_word;
          pc_out_d = pc_q;
          vld_d    = 1'b1;
          pc_d     = pc_q + PC_W'(1);
        end
      end
      S_HALT: begin
        ic_d  = '0;
        vld_d = 1'b0;
        if (start) begin
          state_d = S_LOAD;
          pc_d    = '0;
        end
      end
      default: begin
        state_d = S_LOAD;
        pc_d    = '0;
        ic_d    = '0;
        vld_d   = 1'b0;
      end
    endcase
    running_d = (state_d == S_RUN);
    halted_d  = (state_d == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_LOAD;
      pc_q      <= '0;
      pc_out_q  <= '0;
      ic_q      <= '0;
      vld_q     <= 1'b0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pc_out_q  <= pc_out_d;
      ic_q      <= ic_d;
      vld_q     <= vld_d;
      running_q <= running_d;
      halted_q  <= halted_d;
    end
  end

  assign instruction_code = ic_q;
  assign instr_valid      = vld_q;
  assign pc_out           = pc_out_q;
  assign running          = running_q;
  assign halted           = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a behavioural model predicts each edge's
// outputs into a queue, which is popped and compared once the edge has happened.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [18:0] prog_data;
  logic        start, stall, jump_req, branch_req;
  logic [3:0]  jump_target, branch_target;
  logic [18:0] instruction_code;
  logic        instr_valid;
  logic [3:0]  pc_out;
  logic        flush_jump, branch_flush, running, halted;

  int checks = 0;
  int errors = 0;

  instruction_fetch dut (
    .clk(clk), .reset_n(reset_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .stall(stall), .jump_req(jump_req),
    .jump_target(jump_target), .branch_req(branch_req), .branch_target(branch_target),
    .instruction_code(instruction_code), .instr_valid(instr_valid), .pc_out(pc_out),
    .flush_jump(flush_jump), .branch_flush(branch_flush), .running(running), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [18:0] ic;
    logic        vld;
    logic [3:0]  pco;
    logic        run;
    logic        hlt;
  } exp_t;

  exp_t exp_q[$];

  // model state: 0=LOAD 1=RUN 2=HALT
  logic [18:0] m_mem [16];
  int          m_state;
  logic [3:0]  m_pc, m_pco;
  logic [18:0] m_ic;
  logic        m_vld;

  function automatic logic [18:0] word(int i);
    logic [15:0] hi;
    logic [2:0]  op;
    hi = 16'(i * 1111 + 7);
    op = 3'(i % 6 + 1);
    return {hi, op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    if (!reset_n) begin
      m_state = 0; m_pc = 0; m_ic = 0; m_vld = 0; m_pco = 0;
    end else if (m_state == 0) begin
      if (prog_we) m_mem[prog_addr] = prog_data;
      m_ic = 0; m_vld = 0;
      if (start) begin m_state = 1; m_pc = 0; end
    end else if (m_state == 1) begin
      if (branch_req) begin
        m_pc = branch_target; m_ic = 0; m_vld = 0;
      end else if (jump_req) begin
        m_pc = jump_target; m_ic = 0; m_vld = 0;
      end else if (stall) begin
      end else if (m_mem[m_pc][2:0] == 3'b111) begin
        m_state = 2; m_ic = 0; m_vld = 0;
      end else begin
        m_ic = m_mem[m_pc]; m_pco = m_pc; m_vld = 1; m_pc = m_pc + 4'd1;
      end
    end else begin
      m_ic = 0; m_vld = 0;
      if (start) begin m_state = 0; m_pc = 0; end
    end
  endtask

  task automatic tick();
    exp_t e, g;
    logic in_run;
    #1;
    in_run = reset_n && (m_state == 1);
    chk("branch_flush", 32'(branch_flush), 32'(in_run && branch_req));
    chk("flush_jump", 32'(flush_jump), 32'(in_run && jump_req && !branch_req));
    model_step();
    e = '{ic: m_ic, vld: m_vld, pco: m_pco, run: (m_state == 1), hlt: (m_state == 2)};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 32'd1, 32'd0);
    end else begin
      g = exp_q.pop_front();
      chk("instruction_code", 32'(instruction_code), 32'(g.ic));
      chk("instr_valid", 32'(instr_valid), 32'(g.vld));
      chk("running", 32'(running), 32'(g.run));
      chk("halted", 32'(halted), 32'(g.hlt));
      if (g.vld) chk("pc_out", 32'(pc_out), 32'(g.pco));
    end
  endtask

  task automatic idle();
    prog_we = 0; start = 0; stall = 0; jump_req = 0; branch_req = 0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_mem[i] = 'x;
    m_state = 0; m_pc = 0; m_pco = 0; m_ic = 0; m_vld = 0;
    reset_n = 0; idle();
    prog_addr = 0; prog_data = 0; jump_target = 0; branch_target = 0;
    ticks(2);
    chk("reset_pc_out", 32'(pc_out), 32'd0);
    reset_n = 1;

    // load program with a halt at 3; last write shares a cycle with start
    for (int i = 0; i < 16; i++) begin
      prog_we = 1; prog_addr = 4'(i);
      prog_data = (i == 3) ? {16'h0333, 3'b111} : word(i);
      start = (i == 15);
      tick();
    end
    idle();
    ticks(5);
    chk("halted_after_halt_word", 32'(halted), 32'd1);

    // redirects, stall and writes are ignored in HALT
    jump_req = 1; jump_target = 4'h5; branch_req = 1; branch_target = 4'h6;
    stall = 1; prog_we = 1; prog_addr = 4'h0; prog_data = 19'h0;
    tick();
    idle();
    start = 1; tick(); idle();

    // LOAD: replace the halt at 3, then run
    prog_we = 1; prog_addr = 4'h3; prog_data = word(3); tick(); idle();
    start = 1; tick(); idle();
    ticks(3);
    jump_req = 1; jump_target = 4'hA; tick(); idle();
    ticks(2);
    chk("jump_pc_out", 32'(pc_out), 32'hB);

    // branch wins over a simultaneous jump
    branch_req = 1; branch_target = 4'h2; jump_req = 1; jump_target = 4'h9;
    tick(); idle();
    ticks(3);

    // stall at pc=5, then stall+jump redirects; fetch wraps 15 -> 0
    stall = 1; ticks(3);
    jump_req = 1; jump_target = 4'hE; tick(); idle();
    ticks(4);
    chk("wrap_pc_out", 32'(pc_out), 32'h1);

    // write in RUN is ignored
    prog_we = 1; prog_addr = 4'h4; prog_data = 19'h0; tick(); idle();
    ticks(2);
    chk("ram_unchanged", 32'(instruction_code), 32'(word(4)));

    // reset mid-RUN, RAM intact; redirect beats a halt word at 6
    reset_n = 0; tick(); reset_n = 1;
    chk("reset_mid_run_pc", 32'(pc_out), 32'd0);
    prog_we = 1; prog_addr = 4'h6; prog_data = {16'h0666, 3'b111}; tick(); idle();
    start = 1; tick(); idle();
    ticks(6);
    branch_req = 1; branch_target = 4'h0; tick(); idle();
    ticks(8);
    chk("halted_at_6", 32'(halted), 32'd1);
    start = 1; tick(); idle();
    start = 1; tick(); idle();
    ticks(2);
    chk("refetch_pc_out", 32'(pc_out), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
